// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a 5-stage MIPS pipeline.
//   Word load/store into an internal data memory whose access takes LATENCY cycles.
//   While an access is still in progress the stage stalls the upstream pipeline
//   and sends bubbles into MEM/WB.
//   Illegal accesses are dropped. They raise a one-cycle Out_AddrError pulse.
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   In_Result/In_Data     byte address (or ALU result) and store data from EX
//   In_Rd/In_MEMControl   destination register; {MemRead, MemWrite}
//   In_WBControl          {RegWrite, MemtoReg}
//   Out_ReadData/Result   MEM/WB loaded word and ALU result passthrough
//   Out_Rd/Out_WBControl  MEM/WB destination register and WB control
//   Out_Stall             freezes IF/ID/EX while an access is in progress
//   Out_AddrError         one-cycle pulse for a squashed illegal access
module mem_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] In_Result,
  input  logic [31:0] In_Data,
  input  logic [4:0]  In_Rd,
  input  logic [1:0]  In_MEMControl,
  input  logic [1:0]  In_WBControl,
  output logic [31:0] Out_ReadData,
  output logic [31:0] Out_Result,
  output logic [4:0]  Out_Rd,
  output logic [1:0]  Out_WBControl,
  output logic        Out_Stall,
  output logic        Out_AddrError
);

  localparam int unsigned Words   = 2 ** ADDR_W;
  localparam logic [3:0]  LastCnt = 4'(LATENCY - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       mem_q [Words];

  logic [ADDR_W-1:0] idx;
  logic              mem_read, mem_write, mem_op;
  logic              out_of_range, illegal, legal_mem;
  logic              stall, complete;

  // Address decode
  assign idx          = In_Result[ADDR_W+1:2];
  assign mem_read     = In_MEMControl[1];
  assign mem_write    = In_MEMControl[0];
  assign mem_op       = |In_MEMControl;
  assign out_of_range = (In_Result >> (ADDR_W + 2)) != 32'd0;
  assign illegal      = mem_op && ((In_Result[1:0] != 2'b00) || out_of_range ||
                                   (&In_MEMControl));
  assign legal_mem    = mem_op && !illegal;

  // Access sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (legal_mem) begin
          if (LATENCY <= 1) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StBusy;
            cnt_d   = 4'd1;
          end
        end
      end
      StBusy: begin
        if (cnt_q >= LastCnt) begin
          complete = 1'b1;
          state_d  = StIdle;
          cnt_d    = 4'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // A held reset parks the FSM in idle. Gate the stall here so that a pending
  // legal op does not raise it during reset.
  assign Out_Stall = stall & Rst_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_ReadData  <= 32'd0;
      Out_Result    <= 32'd0;
      Out_Rd        <= 5'd0;
      Out_WBControl <= 2'b00;
      Out_AddrError <= 1'b0;
    end else if (stall) begin
      Out_ReadData  <= 32'd0;
      Out_Result    <= 32'd0;
      Out_Rd        <= 5'd0;
      Out_WBControl <= 2'b00;
      Out_AddrError <= 1'b0;
    end else if (illegal) begin
      Out_ReadData  <= 32'd0;
      Out_Result    <= In_Result;
      Out_Rd        <= 5'd0;
      Out_WBControl <= 2'b00;
      Out_AddrError <= 1'b1;
    end else begin
      Out_ReadData  <= (complete && mem_read) ? mem_q[idx] : 32'd0;
      Out_Result    <= In_Result;
      Out_Rd        <= In_Rd;
      Out_WBControl <= In_WBControl;
      Out_AddrError <= 1'b0;
    end
  end

  // The data array is not reset, so its contents survive Rst_n.
  // The write enable is gated by Rst_n so that an aborted access commits nothing.
  always_ff @(posedge Clk) begin
    if (Rst_n && complete && mem_write) begin
      mem_q[idx] <= In_Data;
    end
  end

endmodule
